// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned     XLEN         = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]     NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_checker.sv
// Simulation-only protocol checks for the fetch front end.
module fetch_checker #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            imem_req_i,
    input  logic            imem_gnt_i,
    input  logic [XLEN-1:0] imem_addr_i,
    input  logic            imem_rvalid_i,
    input  logic            redirect_i,
    input  logic [CW-1:0]   outstanding_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            full_i
);

    // A response is only legal while a granted request is still pending.
    a_rvalid_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (outstanding_i != '0));

    // Credit accounting must never push into a full buffer without a pop.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && full_i) |-> pop_i);

    // An ungranted request keeps its address until grant unless a redirect intervenes.
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (imem_req_i && !imem_gnt_i) |=> (redirect_i || (imem_req_i && $stable(imem_addr_i))));

endmodule

// File: rtl/inst_fifo.sv
// Small in-order FIFO with registered storage and a synchronous flush.
// The head entry is read directly from storage, so data pushed in cycle N
// becomes visible at data_o in cycle N+1.
module inst_fifo #(
    parameter int unsigned DEPTH     = 2,
    parameter type         T         = logic [63:0],
    parameter T            RESET_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          push_s;
    logic          pop_s;

    // Qualify push/pop: a pop on empty is dropped, a push on full needs a same-cycle pop.
    always_comb begin
        pop_s  = pop_i && (cnt_q != '0);
        push_s = push_i && ((cnt_q != FULL_CNT) || pop_s);
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy; flush empties the queue without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_q <= rd_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC ownership, credit-limited request issue,
// in-order response buffering and redirect/flush handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            id_ready_i
);

    localparam int unsigned    AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned    CW       = AW + 1;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1'b1);
    localparam logic [CW:0]    CREDITS  = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);
    localparam fetch_entry_t   ENTRY_RST = '{pc: RESET_PC, inst: NOP_INST};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] tag_q [FIFO_DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;

    logic            req_s;
    logic            grant_s;
    logic            rsp_s;
    logic            tag_pop_s;
    logic            push_s;
    logic            pop_s;
    logic [CW:0]     in_flight_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_s;

    // Handshake qualification: credit-limited issue, redirect kills the request in its own cycle.
    always_comb begin
        in_flight_s  = {1'b0, fifo_count_s} + {1'b0, outstanding_q};
        req_s        = (state_q == FETCH) && (in_flight_s < CREDITS) && !redirect_i;
        grant_s      = req_s && imem_gnt_i;
        rsp_s        = imem_rvalid_i && (outstanding_q != '0);
        tag_pop_s    = rsp_s && (state_q == FETCH);
        push_s       = tag_pop_s && !redirect_i;
        pop_s        = !fifo_empty_s && id_ready_i && !redirect_i;
        push_entry_s = '{pc: tag_q[tag_rd_q], inst: imem_rdata_i};
    end

    // Next-state logic for the FSM, fetch PC and the outstanding/drop counters.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;

        case ({grant_s, rsp_s})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = FETCH;
            end
            FLUSH: begin
                if (rsp_s) begin
                    drop_d = drop_q - CNT_ONE;
                    if (drop_q == CNT_ONE) begin
                        state_d = FETCH;
                    end else begin
                        state_d = FLUSH;
                    end
                end else begin
                    drop_d = drop_q;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (grant_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // Every response still owed after this cycle belongs to the old stream.
        if (redirect_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            drop_d     = outstanding_d;
            if (outstanding_d != '0) begin
                state_d = FLUSH;
            end else begin
                state_d = FETCH;
            end
        end else begin
            drop_d = drop_d;
        end
    end

    // FSM, PC, counters and the PC tag queue that pairs responses with their address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i] <= RESET_PC;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (redirect_i) begin
                tag_wr_q <= '0;
                tag_rd_q <= '0;
            end else begin
                if (grant_s) begin
                    tag_q[tag_wr_q] <= fetch_pc_q;
                    tag_wr_q        <= tag_wr_q + PTR_ONE;
                end
                if (tag_pop_s) begin
                    tag_rd_q <= tag_rd_q + PTR_ONE;
                end
            end
        end
    end

    inst_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .T         (fetch_entry_t),
        .RESET_VAL (ENTRY_RST)
    ) u_inst_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    fetch_checker #(
        .XLEN (XLEN),
        .CW   (CW)
    ) u_fetch_checker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_i    (req_s),
        .imem_gnt_i    (imem_gnt_i),
        .imem_addr_i   (fetch_pc_q),
        .imem_rvalid_i (imem_rvalid_i),
        .redirect_i    (redirect_i),
        .outstanding_i (outstanding_q),
        .push_i        (push_s),
        .pop_i         (pop_s),
        .full_i        (fifo_full_s)
    );

    assign imem_req_o  = req_s;
    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = !fifo_empty_s;
    assign inst_o      = head_s.inst;
    assign pc_o        = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level reference model:
// an in-order memory responder plus counts of live, buffered and dropped fetches.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        id_ready_i = 1'b0;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .id_ready_i    (id_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          live, arrived, dropping;
    bit          boot;
    logic [31:0] exp_fetch, exp_pc;
    int          p_gnt, p_rv, p_rdy, dmin, dmax;
    int          first_g, first_v;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_mode(input int g, input int rv, input int rdy, input int lo, input int hi);
        p_gnt = g; p_rv = rv; p_rdy = rdy; dmin = lo; dmax = hi;
    endtask

    // Entered and left at a falling edge; reset is asserted asynchronously.
    task automatic apply_reset();
        rst_ni = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; id_ready_i = 1'b0;
        pend.delete();
        live = 0; arrived = 0; dropping = 0; boot = 1'b1;
        exp_fetch = RESET_PC; exp_pc = RESET_PC;
        #1;
        check_eq("rst_req", imem_req_o, 1'b0);
        check_eq("rst_addr", imem_addr_o, RESET_PC);
        check_eq("rst_valid", valid_o, 1'b0);
        check_eq("rst_inst", inst_o, NOP);
        check_eq("rst_pc", pc_o, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // One cycle: drive inputs, compare against the model, advance the model across the edge.
    task automatic step(input logic redir, input logic [31:0] rpc);
        logic rv, g, p, exp_req;
        imem_gnt_i    = ($urandom_range(99) < p_gnt);
        id_ready_i    = ($urandom_range(99) < p_rdy);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        rv = 1'b0;
        imem_rdata_i = 32'h0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc && $urandom_range(99) < p_rv) begin
                rv = 1'b1;
                imem_rdata_i = mem_word(pend[0].addr);
            end
        end
        imem_rvalid_i = rv;
        #1;
        exp_req = !redir && !boot && (dropping == 0) && (live < DEPTH);
        check_eq("req", imem_req_o, exp_req);
        if (exp_req) check_eq("addr", imem_addr_o, exp_fetch);
        check_eq("valid", valid_o, arrived > 0);
        if (arrived > 0) begin
            check_eq("pc", pc_o, exp_pc);
            check_eq("inst", inst_o, mem_word(exp_pc));
        end
        if (first_g < 0 && exp_req && imem_gnt_i) first_g = cyc;
        if (first_v < 0 && valid_o) first_v = cyc;

        g = exp_req && imem_gnt_i;
        p = (arrived > 0) && id_ready_i && !redir;
        if (p) begin
            exp_pc += 32'd4; live--; arrived--;
        end
        if (g) begin
            pend.push_back('{addr: exp_fetch, due: cyc + int'($urandom_range(dmax, dmin))});
            exp_fetch += 32'd4; live++;
        end
        if (rv) begin
            void'(pend.pop_front());
            if (dropping > 0) dropping--;
            else if (!redir) arrived++;
        end
        if (redir) begin
            exp_fetch = {rpc[31:2], 2'b00};
            exp_pc    = {rpc[31:2], 2'b00};
            live = 0; arrived = 0;
            dropping = pend.size();
        end
        boot = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int p_redir);
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step($urandom_range(99) < p_redir, rpc);
        end
    endtask

    initial begin
        first_g = -1; first_v = -1;
        set_mode(100, 100, 100, 1, 1);
        apply_reset();

        // Streaming: grant always, response next cycle, decode always ready.
        run(20, 0);
        check_eq("latency", 32'(first_v - first_g), 32'd2);

        // Decode stalls: two grants then request drops; release drains in order.
        set_mode(100, 100, 0, 1, 2);
        run(10, 0);
        check_eq("hold_req", imem_req_o, 1'b0);
        check_eq("hold_valid", valid_o, 1'b1);
        set_mode(100, 100, 100, 1, 2);
        run(10, 0);

        // Grant withheld: request and address must sit still.
        set_mode(0, 100, 100, 1, 1);
        run(5, 0);
        set_mode(100, 100, 100, 1, 1);
        run(5, 0);

        // Redirect with two slow responses outstanding.
        set_mode(100, 100, 100, 3, 3);
        run(4, 0);
        step(1'b1, 32'h0000_0103);
        run(12, 0);

        // Redirect in steady state where pop and rvalid coincide.
        set_mode(100, 100, 100, 1, 1);
        run(6, 0);
        step(1'b1, 32'h0000_2000);
        run(8, 0);

        // Address wrap at the top of the space.
        step(1'b1, 32'hFFFF_FFF8);
        run(10, 0);

        // Randomized traffic with redirects, including during flush.
        for (int k = 0; k < 6; k++) begin
            set_mode($urandom_range(100, 20), $urandom_range(100, 30), $urandom_range(100, 0), 1,
                     $urandom_range(5, 1));
            run(400, 4);
        end

        // Asynchronous reset in the middle of a burst, then recover.
        set_mode(100, 100, 100, 2, 3);
        run(5, 0);
        #2;
        apply_reset();
        run(30, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that owns the PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small in-order FIFO. It presents {pc, inst} pairs to the decode stage with a valid/ready handshake. It replaces the bare PC/adder path ahead of instruction decode and accepts branch/jump redirects from later stages.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch word address, bits [1:0] always 0
imem_gnt_i  in  1  request accepted this cycle (qualified by imem_req_o)
imem_rvalid_i  in  1  response valid; responses return in order, >= 1 cycle after grant
imem_rdata_i  in  32  instruction word
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
valid_o  out  1  inst_o/pc_o hold a valid instruction
inst_o  out  32  instruction to decode
pc_o  out  XLEN  address of inst_o
id_ready_i  in  1  decode consumes when valid_o && id_ready_i

Behaviour:
- Reset (async, rst_ni low): state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; outputs imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=RESET_PC.
- FSM states:
  - BOOT: one cycle after reset release with no request, then FETCH.
  - FETCH: normal operation.
  - FLUSH: entered on redirect while outstanding>0 (counting a grant in the same cycle). Return to FETCH when drop reaches 0 (after the final discarded rvalid).
- Issue rule (FETCH only): imem_req_o = (fifo_count + outstanding < FIFO_DEPTH). imem_addr_o = fetch_pc.
- Stability: once imem_req_o is raised, req and addr hold until grant. The only exception is redirect.
- Grant: on imem_req_o && imem_gnt_i, outstanding+1 and fetch_pc += 4, wrapping modulo 2^XLEN. A grant without a request is ignored.
- Response: on rvalid in FETCH, push {pc_tag, rdata} and decrement outstanding. pc_tag is carried in a tag queue of depth FIFO_DEPTH.
- Response in FLUSH: rvalid decrements drop and outstanding; the data is discarded.
- Credit rule guarantees no FIFO overflow. An rvalid with outstanding=0 is a protocol error: ignore it, with an assertion in simulation.
- Output: valid_o = FIFO not empty; inst_o/pc_o = FIFO head; pop on valid_o && id_ready_i.
  - Latency: a grant in cycle N with rvalid in N+1 gives valid_o in N+2 (registered FIFO).
  - Push and pop in the same cycle with FIFO full or empty are both legal; count is unchanged for a full FIFO.
- Redirect (any state): in the same cycle the FIFO and tag queue are cleared, any pop is ignored, and fetch_pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - drop <= outstanding (including a same-cycle grant, minus a same-cycle rvalid).
  - imem_req_o is deasserted combinationally that cycle. Next state is FLUSH if drop>0, else FETCH.
  - valid_o is 0 on the next cycle.
  - Redirect during FLUSH reloads fetch_pc and recomputes drop the same way.
  - Redirect during BOOT is honoured and fetch starts at the new pc.
- Counters: outstanding and drop are $clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Package fetch_pkg: XLEN, RESET_PC default, NOP constant 32'h0000_0013, fetch_state_e {BOOT, FETCH, FLUSH}, typedef fetch_entry_t {pc, inst}.
- Sub-module inst_fifo (parameterised depth, synchronous flush input, push/pop/full/empty/count). It is instantiated once with fetch_entry_t as payload.

Test Plan:
- Reset release with gnt tied 1 and rvalid one cycle after grant, id_ready=1 -> addresses 0x0,0x4,0x8,…; valid_o first rises 2 cycles after first grant; pc_o tracks inst_o.
- id_ready=0 held -> after 2 grants imem_req_o=0; FIFO holds 0x0/0x4; release ready -> in-order delivery, no drop or duplicate.
- gnt held 0 for 5 cycles -> imem_req_o=1 and imem_addr_o stable throughout.
- Redirect to 0x103 with 2 outstanding -> next req addr 0x100; the 2 late responses are discarded; first valid_o has pc_o=0x100.
- Redirect in the same cycle as pop and rvalid -> FIFO cleared, rvalid counted in drop math, no stale instruction appears.
- fetch_pc=0xFFFF_FFFC granted -> next request addr 0x0000_0000; async reset mid-burst -> all outputs return to reset values immediately.
